ex_flag_stage: RTL and testbench

//  Stage directly downstream of the 16-bit saturating CLA adder/ALU. Registers the ALU

---
 rtl/ex_flag_stage.sv | 143 ++++++++++++++
 tb/tb_ex_flag_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX/MEM pipeline register behind the saturating CLA ALU.
// Holds the registered ALU result and valid bit, the architected N/Z/V
// flag register with per-opcode write enables, and evaluates the branch
// condition against the committed (pre-update) flags.
module ex_flag_stage #(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_N,
    input  logic          alu_Z,
    input  logic          alu_V,
    input  logic          br_check,
    input  logic [2:0]    br_cond,
    output logic [DW-1:0] mem_result,
    output logic          mem_valid,
    output logic          flag_N,
    output logic          flag_Z,
    output logic          flag_V,
    output logic          br_taken
);

    // Architected flag register.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Branch condition encodings as seen on br_cond.
    typedef enum logic [2:0] {
        BR_NE = 3'b000,
        BR_EQ = 3'b001,
        BR_GT = 3'b010,
        BR_LT = 3'b011,
        BR_GE = 3'b100,
        BR_LE = 3'b101,
        BR_OV = 3'b110,
        BR_AL = 3'b111
    } br_cond_e;

    // Opcodes that touch the flag register; everything else leaves flags alone.
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR = OPW'(2);
    localparam logic [OPW-1:0] OP_SLL = OPW'(4);
    localparam logic [OPW-1:0] OP_SRA = OPW'(5);
    localparam logic [OPW-1:0] OP_ROR = OPW'(6);

    flags_t   flags_q;
    logic     commit;
    logic     wr_nv;
    logic     wr_z;
    logic     cond_met;
    br_cond_e cond;

    // An instruction retires into EX/MEM only if real, not stalled and not squashed.
    assign commit = ex_valid & ~stall & ~flush;

    // Decode which flags the instruction in EX is allowed to write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave a value held (latch).
        wr_nv = 1'b0;
        wr_z  = 1'b0;
        case (ex_opcode)
            OP_ADD, OP_SUB: begin
                wr_nv = 1'b1;
                wr_z  = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                wr_z = 1'b1;
            end
            default: begin
                wr_nv = 1'b0;
                wr_z  = 1'b0;
            end
        endcase
    end

    // EX/MEM register: flush clears (and wins over stall), stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            mem_result <= '0;
            mem_valid  <= 1'b0;
        end else if (flush) begin
            mem_result <= '0;
            mem_valid  <= 1'b0;
        end else if (!stall) begin
            mem_result <= alu_result;
            mem_valid  <= ex_valid;
        end
    end

    // Flag register: written only on commit, field by field per opcode class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (commit) begin
            if (wr_nv) begin
                flags_q.n <= alu_N;
                flags_q.v <= alu_V;
            end
            if (wr_z) begin
                flags_q.z <= alu_Z;
            end
        end
    end

    assign flag_N = flags_q.n;
    assign flag_Z = flags_q.z;
    assign flag_V = flags_q.v;

    assign cond = br_cond_e'(br_cond);

    // Branch evaluation uses the flags as currently held, never the ALU's
    // in-flight flags; the forwarding hazard is handled by pipeline control.
    always_comb begin
        cond_met = 1'b0;
        case (cond)
            BR_NE:   cond_met = ~flags_q.z;
            BR_EQ:   cond_met = flags_q.z;
            BR_GT:   cond_met = ~flags_q.z & ~flags_q.n;
            BR_LT:   cond_met = flags_q.n;
            BR_GE:   cond_met = flags_q.z | (~flags_q.z & ~flags_q.n);
            BR_LE:   cond_met = flags_q.n | flags_q.z;
            BR_OV:   cond_met = flags_q.v;
            BR_AL:   cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign br_taken = br_check & cond_met;

endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: randomized and directed stimulus for ex_flag_stage.
// A reference model predicts each cycle's registered state and branch
// outcome; expectations are queued with the cycle they apply to and a
// separate monitor pops and compares them on the falling edge.
module tb_ex_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [15:0] alu_result = '0;
    logic        alu_N = 1'b0;
    logic        alu_Z = 1'b0;
    logic        alu_V = 1'b0;
    logic        br_check = 1'b0;
    logic [2:0]  br_cond = '0;
    logic [15:0] mem_result;
    logic        mem_valid;
    logic        flag_N;
    logic        flag_Z;
    logic        flag_V;
    logic        br_taken;

    ex_flag_stage #(.DW(16), .OPW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .alu_result (alu_result),
        .alu_N      (alu_N),
        .alu_Z      (alu_Z),
        .alu_V      (alu_V),
        .br_check   (br_check),
        .br_cond    (br_cond),
        .mem_result (mem_result),
        .mem_valid  (mem_valid),
        .flag_N     (flag_N),
        .flag_Z     (flag_Z),
        .flag_V     (flag_V),
        .br_taken   (br_taken)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced on each rising edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // One stimulus cycle.
    typedef struct {
        bit          rst;
        bit          vld;
        logic [3:0]  op;
        logic [15:0] res;
        bit          n, z, v;
        bit          stall, flush;
        bit          chk;
        logic [2:0]  cond;
    } txn_t;

    // One expectation, due at the falling edge of cycle 'cyc'.
    typedef struct {
        bit          is_br;
        int          cyc;
        logic [15:0] res;
        bit          vld, n, z, v;
        bit          br;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [15:0] m_res = '0;
    bit          m_vld = 1'b0;
    bit          m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;

    // Branch outcome from the meaning of each condition, reading the flags
    // as the sign/zero/overflow classification of the last compare.
    function automatic bit br_model(bit chk, logic [2:0] cond, bit n, bit z, bit v);
        bit is_zero = z;
        bit is_neg  = n;
        bit ok;
        case (int'(cond))
            0: ok = !is_zero;
            1: ok = is_zero;
            2: ok = !is_zero && !is_neg;
            3: ok = is_neg;
            4: ok = is_zero || !is_neg;
            5: ok = is_neg || is_zero;
            6: ok = v;
            default: ok = 1'b1;
        endcase
        return chk && ok;
    endfunction

    function automatic exp_t mk_res(int c);
        exp_t e;
        e.is_br = 1'b0;
        e.cyc = c;
        e.res = m_res;
        e.vld = m_vld;
        e.n = m_n;
        e.z = m_z;
        e.v = m_v;
        e.br = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_br(int c, bit chk, logic [2:0] cond);
        exp_t e;
        e = mk_res(c);
        e.is_br = 1'b1;
        e.br = br_model(chk, cond, m_n, m_z, m_v);
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show.
    task automatic apply(input txn_t t);
        bit commit;
        rst_n      = !t.rst;
        ex_valid   = t.vld;
        ex_opcode  = t.op;
        alu_result = t.res;
        alu_N      = t.n;
        alu_Z      = t.z;
        alu_V      = t.v;
        stall      = t.stall;
        flush      = t.flush;
        br_check   = t.chk;
        br_cond    = t.cond;
        if (t.rst) begin
            // Reset wipes state immediately, so pending predictions are void.
            while (q.size() > 0 && q[q.size()-1].cyc >= cyc) void'(q.pop_back());
            m_res = '0;
            m_vld = 1'b0;
            m_n = 1'b0;
            m_z = 1'b0;
            m_v = 1'b0;
            q.push_back(mk_res(cyc));
            q.push_back(mk_br(cyc, t.chk, t.cond));
            q.push_back(mk_res(cyc + 1));
        end else begin
            q.push_back(mk_br(cyc, t.chk, t.cond));
            commit = t.vld && !t.stall && !t.flush;
            if (t.flush) begin
                m_res = '0;
                m_vld = 1'b0;
            end else if (!t.stall) begin
                m_res = t.res;
                m_vld = t.vld;
            end
            if (commit) begin
                if (t.op inside {4'd0, 4'd1}) begin
                    m_n = t.n;
                    m_z = t.z;
                    m_v = t.v;
                end else if (t.op inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
                    m_z = t.z;
                end
            end
            q.push_back(mk_res(cyc + 1));
        end
    endtask

    task automatic drive(input txn_t t);
        @(posedge clk);
        #1;
        apply(t);
    endtask

    function automatic txn_t mk_op(logic [3:0] op, logic [15:0] res, bit n, bit z, bit v,
                                   bit st, bit fl);
        txn_t t;
        t.rst = 1'b0;
        t.vld = 1'b1;
        t.op = op;
        t.res = res;
        t.n = n;
        t.z = z;
        t.v = v;
        t.stall = st;
        t.flush = fl;
        t.chk = 1'b0;
        t.cond = 3'd0;
        return t;
    endfunction

    function automatic txn_t mk_idle(bit chk, logic [2:0] cond);
        txn_t t;
        t = mk_op(4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t.vld = 1'b0;
        t.chk = chk;
        t.cond = cond;
        return t;
    endfunction

    task automatic do_reset();
        txn_t t;
        t = mk_idle(1'b1, 3'd7);
        t.rst = 1'b1;
        drive(t);
        drive(mk_idle(1'b0, 3'd0));
    endtask

    // Monitor: compare every expectation due at this falling edge.
    exp_t me;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            total++;
            if (me.cyc < cyc) begin
                bad++;
                $display("FAIL stale_expectation cyc=%0d due=%0d", cyc, me.cyc);
            end else if (me.is_br) begin
                if (br_taken !== me.br) begin
                    bad++;
                    $display("FAIL br_taken cyc=%0d flags=%b%b%b chk=%b cond=%0d got=%b exp=%b",
                             cyc, flag_N, flag_Z, flag_V, br_check, br_cond, br_taken, me.br);
                end
            end else begin
                if ({mem_valid, flag_N, flag_Z, flag_V, mem_result} !==
                    {me.vld, me.n, me.z, me.v, me.res}) begin
                    bad++;
                    $display("FAIL state cyc=%0d got vld=%b nzv=%b%b%b res=%h exp vld=%b nzv=%b%b%b res=%h",
                             cyc, mem_valid, flag_N, flag_Z, flag_V, mem_result,
                             me.vld, me.n, me.z, me.v, me.res);
                end
            end
        end
    end

    initial begin
        txn_t t;
        do_reset();

        // SUB producing zero, then EQ branch on the committed Z.
        drive(mk_op(4'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        drive(mk_idle(1'b1, 3'd1));

        // Saturating ADD sets V; OV branch; XOR writes Z only.
        drive(mk_op(4'd0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(mk_idle(1'b1, 3'd6));
        drive(mk_op(4'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        drive(mk_idle(1'b1, 3'd5));

        // Stall holds everything; release lets the ADD through.
        drive(mk_op(4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(mk_op(4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(mk_op(4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Stall and flush together: flush wins, flags untouched.
        drive(mk_op(4'd1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));

        // Non-flag opcode with Z set: result moves, flags do not.
        drive(mk_op(4'd8, 16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

        // Every condition against every flag combination, plus br_check=0.
        for (int f = 0; f < 8; f++) begin
            drive(mk_op(4'd0, 16'(f), f[2], f[1], f[0], 1'b0, 1'b0));
            for (int c = 0; c < 8; c++) drive(mk_idle(1'b1, 3'(c)));
            drive(mk_idle(1'b0, 3'($urandom_range(0, 7))));
        end

        // Reset in the middle of activity, then a clean first commit.
        drive(mk_op(4'd1, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(mk_idle(1'b1, 3'd3));
        do_reset();
        drive(mk_op(4'd0, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(mk_idle(1'b1, 3'd2));

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                t = mk_op(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
                t.vld  = $urandom_range(0, 3) != 0;
                t.chk  = 1'($urandom);
                t.cond = 3'($urandom_range(0, 7));
                drive(t);
            end
        end

        // Let the monitor consume what is still due, within a bound.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
